// File: rtl/arb832_rr.sv
// Round-robin 8:1 arbiter with registered valid/ready output stage for the shared result mux.
// Define ARB_LOCK_EN to let a requester holding lock keep the path for up to MAX_LOCK grants.
module arb832_rr #(
    parameter int DW       = 32,
    parameter int MAX_LOCK = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      req,
    input  logic [8*DW-1:0] din,
    input  logic [7:0]      lock,
    input  logic            out_ready,
    output logic [7:0]      gnt,
    output logic [2:0]      sel,
    output logic            out_valid,
    output logic [DW-1:0]   out_data
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q;
    logic [2:0]      ptr_q;
    logic [2:0]      sel_q;
    logic [7:0]      gnt_q;
    logic            out_valid_q;
    logic [DW-1:0]   out_data_q;

    logic [2:0]      scan_base;
    logic [7:0]      cand;
    logic [2:0]      win_idx;
    logic            any_cand;
    logic            relock;

    // In BUSY the scan starts after the finishing requester, which is also
    // masked out so it cannot win twice in a row through round-robin.
    always_comb begin
        scan_base = (state_q == BUSY) ? sel_q : ptr_q;
        cand      = (state_q == BUSY) ? (req & ~gnt_q) : req;
        win_idx   = 3'd0;
        for (int k = 8; k >= 1; k--) begin
            if (cand[scan_base + 3'(k)]) begin
                win_idx = scan_base + 3'(k);
            end
        end
        any_cand = |cand;
    end

`ifdef ARB_LOCK_EN
    logic [3:0] lcnt_q;

    assign relock = lock[sel_q] & req[sel_q] & ((32'(lcnt_q) + 32'd1) < 32'(MAX_LOCK));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lcnt_q <= 4'd0;
        end else if (state_q == BUSY && out_ready) begin
            lcnt_q <= relock ? lcnt_q + 4'd1 : 4'd0;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^lock;
    assign relock      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 3'd7;
            sel_q       <= 3'd0;
            gnt_q       <= 8'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_cand) begin
                        state_q     <= BUSY;
                        sel_q       <= win_idx;
                        gnt_q       <= 8'd1 << win_idx;
                        out_valid_q <= 1'b1;
                        out_data_q  <= din[DW*int'(win_idx) +: DW];
                    end
                end
                BUSY: begin
                    if (out_ready) begin
                        if (relock) begin
                            out_data_q <= din[DW*int'(sel_q) +: DW];
                        end else begin
                            ptr_q <= sel_q;
                            if (any_cand) begin
                                sel_q      <= win_idx;
                                gnt_q      <= 8'd1 << win_idx;
                                out_data_q <= din[DW*int'(win_idx) +: DW];
                            end else begin
                                state_q     <= IDLE;
                                gnt_q       <= 8'd0;
                                out_valid_q <= 1'b0;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_arb832_rr.sv
// Self-checking bench for arb832_rr: directed vector table, corner sequences, random vs. reference model.
module tb_arb832_rr;

    localparam int DW       = 32;
    localparam int MAX_LOCK = 4;

    logic            clk;
    logic            rst_n;
    logic [7:0]      req;
    logic [8*DW-1:0] din;
    logic [7:0]      lock;
    logic            out_ready;
    logic [7:0]      gnt;
    logic [2:0]      sel;
    logic            out_valid;
    logic [DW-1:0]   out_data;

    logic [31:0]     dw [8];

    int cmp_cnt = 0;
    int err_cnt = 0;

    // reference model state
    bit          m_busy;
    bit          m_fresh;
    int          m_last;
    int          m_sel;
    int          m_run;
    logic [31:0] m_data;

    arb832_rr #(.DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .din       (din),
        .lock      (lock),
        .out_ready (out_ready),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 8; i++) din[32*i +: 32] = dw[i];
    end

    typedef struct packed {
        logic        rst_n;
        logic [7:0]  req;
        logic        rdy;
        logic        exp_valid;
        logic [7:0]  exp_gnt;
        logic [2:0]  exp_sel;
        logic [31:0] exp_data;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [7:0] r, input int last);
        for (int k = 1; k <= 8; k++) begin
            if (r[(last + k) % 8]) return (last + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_step();
        int  w;
        bit  regrant;
        regrant = 1'b0;
        if (!rst_n) begin
            m_busy = 0; m_fresh = 1; m_last = 7; m_sel = 0; m_run = 0; m_data = 32'h0;
        end else if (!m_busy) begin
            w = pick(req, m_last);
            if (w >= 0) begin
                m_busy = 1; m_fresh = 0; m_sel = w; m_data = dw[w]; m_run = 1;
            end
        end else if (out_ready) begin
`ifdef ARB_LOCK_EN
            if (lock[m_sel] && req[m_sel] && m_run < MAX_LOCK) begin
                regrant = 1'b1;
                m_run++;
                m_data = dw[m_sel];
            end
`endif
            if (!regrant) begin
                m_last = m_sel;
                w = pick(req & ~(8'd1 << m_sel), m_last);
                if (w >= 0) begin
                    m_sel = w; m_data = dw[w]; m_run = 1;
                end else begin
                    m_busy = 0; m_run = 0;
                end
            end
        end
    endtask

    task automatic check_model();
        check("model_valid", {31'd0, out_valid}, {31'd0, m_busy});
        check("model_gnt", {24'd0, gnt}, m_busy ? (32'd1 << m_sel) : 32'd0);
        if (m_busy || m_fresh) begin
            check("model_sel", {29'd0, sel}, 32'(m_sel));
            check("model_data", out_data, m_data);
        end
    endtask

    task automatic apply(input logic r, input logic [7:0] q, input logic [7:0] lk, input logic rd);
        rst_n = r; req = q; lock = lk; out_ready = rd;
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    vec_t vecs[$];
    int   exp_lock[6];
    logic [31:0] held;

    initial begin
        rst_n = 1'b0; req = 8'h00; lock = 8'h00; out_ready = 1'b0;
        for (int i = 0; i < 8; i++) dw[i] = 32'hA5A5_0001 + 32'(i);
        m_busy = 0; m_fresh = 1; m_last = 7; m_sel = 0; m_run = 0; m_data = 32'h0;

        // directed table: single request, full sweep, wrap 7->0
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 32'h0});
        vecs.push_back('{1'b1, 8'h01, 1'b1, 1'b1, 8'h01, 3'd0, 32'hA5A5_0001});
        vecs.push_back('{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 32'h0});
        vecs.push_back('{1'b0, 8'hFF, 1'b1, 1'b0, 8'h00, 3'd0, 32'h0});
        for (int i = 0; i < 8; i++)
            vecs.push_back('{1'b1, 8'hFF, 1'b1, 1'b1, 8'(1 << i), 3'(i), 32'hA5A5_0001 + 32'(i)});
        vecs.push_back('{1'b1, 8'h81, 1'b1, 1'b1, 8'h01, 3'd0, 32'hA5A5_0001});
        vecs.push_back('{1'b1, 8'h81, 1'b1, 1'b1, 8'h80, 3'd7, 32'hA5A5_0008});
        vecs.push_back('{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 32'h0});

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst_n, vecs[i].req, 8'h00, vecs[i].rdy);
            check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d_gnt", i), {24'd0, gnt}, {24'd0, vecs[i].exp_gnt});
            if (vecs[i].exp_valid || !vecs[i].rst_n) begin
                check($sformatf("vec%0d_sel", i), {29'd0, sel}, {29'd0, vecs[i].exp_sel});
                check($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
            end
        end

        // hold: grant 3, consumer stalls while inputs churn
        apply(1'b0, 8'h00, 8'h00, 1'b0);
        held = dw[3];
        apply(1'b1, 8'h08, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            dw[3] = $urandom;
            apply(1'b1, 8'($urandom), 8'h00, 1'b0);
            check("hold_sel", {29'd0, sel}, 32'd3);
            check("hold_gnt", {24'd0, gnt}, 32'h08);
            check("hold_data", out_data, held);
        end
        apply(1'b1, 8'h00, 8'h00, 1'b1);
        check("hold_done_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 8; i++) dw[i] = 32'hA5A5_0001 + 32'(i);

        // lock burst
`ifdef ARB_LOCK_EN
        exp_lock = '{1, 1, 1, 1, 2, 1};
`else
        exp_lock = '{1, 2, 1, 2, 1, 2};
`endif
        apply(1'b0, 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 6; i++) begin
            dw[1] = $urandom;
            apply(1'b1, 8'h06, 8'h02, 1'b1);
            check($sformatf("lock_sel%0d", i), {29'd0, sel}, 32'(exp_lock[i]));
        end

        // reset in the middle of a transfer to requester 5
        apply(1'b0, 8'h00, 8'h00, 1'b0);
        apply(1'b1, 8'h20, 8'h00, 1'b0);
        check("mid_sel5", {29'd0, sel}, 32'd5);
        apply(1'b1, 8'h20, 8'h00, 1'b0);
        apply(1'b0, 8'hFF, 8'h00, 1'b0);
        check("mid_rst_gnt", {24'd0, gnt}, 32'd0);
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_data", out_data, 32'd0);
        apply(1'b1, 8'hFF, 8'h00, 1'b1);
        check("mid_first_sel", {29'd0, sel}, 32'd0);
        check("mid_first_gnt", {24'd0, gnt}, 32'h01);

        // randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            for (int j = 0; j < 8; j++) if ($urandom_range(0, 3) == 0) dw[j] = $urandom;
            apply($urandom_range(0, 63) != 0,
                  8'($urandom & $urandom),
                  8'($urandom),
                  $urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
